// File: rtl/fifo1_pkg.sv
// Shared constants, state encoding and keep-mask helper for the fifo1 read-side packer.
package fifo1_pkg;

  localparam int FIFO1_DSIZE    = 8;
  localparam int FIFO1_PACK     = 4;
  localparam int FIFO1_CNT_W    = $clog2(FIFO1_PACK) + 1;
  localparam int FIFO1_MAX_PACK = 8;

  typedef enum logic [0:0] {FILL = 1'b0, FLUSH_WAIT = 1'b1} fifo1_state_e;

  localparam logic [0:0] ST_FILL       = FILL;
  localparam logic [0:0] ST_FLUSH_WAIT = FLUSH_WAIT;

  // Thermometer mask of the lanes holding data; MSB-first fills from lane pack-1 downward.
  function automatic logic [FIFO1_MAX_PACK-1:0] keep_from_cnt(input int cnt, input int pack,
                                                              input bit msb_first);
    logic [FIFO1_MAX_PACK-1:0] k;
    k = '0;
    for (int i = 0; i < FIFO1_MAX_PACK; i++) begin
      if (msb_first) k[i] = (i < pack) && (i >= pack - cnt);
      else           k[i] = (i < cnt);
    end
    return k;
  endfunction

endpackage

// File: rtl/fifo1_out_slice.sv
// Valid/ready output register for the packer; accepts a new word only when empty or draining.
module fifo1_out_slice
  import fifo1_pkg::*;
#(
  parameter int W = FIFO1_DSIZE * FIFO1_PACK,
  parameter int K = FIFO1_PACK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic [K-1:0] load_keep,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic [K-1:0] keep,
  output logic         valid,
  output logic         free
);

  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      keep  <= '0;
      valid <= 1'b0;
    end else if (load && free) begin
      data  <= load_data;
      keep  <= load_keep;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo1_rd_packer.sv
// Packs PACK bytes from the fifo1 read port into one keep-masked valid/ready word.
// Define FIFO1_RD_PACKER_MSB_FIRST_EN to place the first byte of each word in the top lane.
module fifo1_rd_packer
  import fifo1_pkg::*;
#(
  parameter int DSIZE = FIFO1_DSIZE,
  parameter int PACK  = FIFO1_PACK
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DSIZE-1:0]      rdata,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic                  flush,
  output logic [DSIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CW = $clog2(PACK) + 1;
`ifdef FIFO1_RD_PACKER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  typedef logic [CW-1:0] cnt_t;

  cnt_t                  cnt, cnt_pop, cnt_d, lane;
  logic [DSIZE*PACK-1:0] acc, acc_pop, acc_d, load_data;
  logic [PACK-1:0]       load_keep, keep_part;
  logic [FIFO1_MAX_PACK-1:0] keep_full;
  logic [0:0]            state, state_d;
  logic                  out_free, load, complete;

  // The last lane may only be filled when the output register can take the finished word.
  assign rinc = !rrst && !rempty && (state == ST_FILL) &&
                ((cnt < cnt_t'(PACK - 1)) || out_free);

  always_comb begin
    lane    = MSB_FIRST ? (cnt_t'(PACK - 1) - cnt) : cnt;
    acc_pop = acc;
    for (int i = 0; i < PACK; i++) begin
      if (rinc && (lane == cnt_t'(i))) acc_pop[i*DSIZE +: DSIZE] = rdata;
    end
    cnt_pop   = rinc ? (cnt + cnt_t'(1)) : cnt;
    complete  = rinc && (cnt == cnt_t'(PACK - 1));
    keep_full = keep_from_cnt(int'(cnt_pop), PACK, MSB_FIRST);
    keep_part = keep_full[PACK-1:0];

    load      = 1'b0;
    load_data = acc_pop;
    load_keep = '1;
    cnt_d     = cnt_pop;
    acc_d     = acc_pop;
    state_d   = state;

    if (state == ST_FLUSH_WAIT) begin
      if (out_free) begin
        load      = 1'b1;
        load_keep = keep_part;
        cnt_d     = '0;
        acc_d     = '0;
        state_d   = ST_FILL;
      end
    end else if (complete) begin
      // A flush landing on the completing pop is satisfied by the full word itself.
      load  = 1'b1;
      cnt_d = '0;
      acc_d = '0;
    end else if (flush && (cnt_pop != '0)) begin
      if (out_free) begin
        load      = 1'b1;
        load_keep = keep_part;
        cnt_d     = '0;
        acc_d     = '0;
      end else begin
        state_d = ST_FLUSH_WAIT;
      end
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      cnt   <= '0;
      acc   <= '0;
      state <= ST_FILL;
    end else begin
      cnt   <= cnt_d;
      acc   <= acc_d;
      state <= state_d;
    end
  end

  fifo1_out_slice #(.W(DSIZE * PACK), .K(PACK)) u_out (
    .clk       (rclk),
    .rst       (rrst),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .ready     (out_ready),
    .data      (out_data),
    .keep      (out_keep),
    .valid     (out_valid),
    .free      (out_free)
  );

endmodule

// File: tb/tb_fifo1_rd_packer.sv
// Self-checking bench for fifo1_rd_packer: vector table, corner-case sequences, random stream.
module tb_fifo1_rd_packer;
  import fifo1_pkg::*;

  localparam int DSIZE = 8;
  localparam int PACK  = 4;
  localparam int W     = DSIZE * PACK;
`ifdef FIFO1_RD_PACKER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic            rclk = 1'b0;
  logic            rrst = 1'b1;
  logic            rempty, rinc, flush, out_valid, out_ready;
  logic [DSIZE-1:0] rdata;
  logic [W-1:0]    out_data;
  logic [PACK-1:0] out_keep;

  logic [7:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    bit         rst_before;
    bit         ready;
    bit         fl;
    bit         exp_rinc;
    bit         exp_valid;
    bit         chk_data;
    logic [31:0] exp_data;
    logic [3:0] exp_keep;
    bit         chk_cnt;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [22];

  fifo1_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 rclk = ~rclk;

  // First-word fall-through FIFO model feeding the packer.
  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = fifo_mem[rd_ptr[9:0]];
  always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 1;

  task automatic fifoPush(input logic [7:0] b);
    fifo_mem[wr_ptr[9:0]] = b;
    wr_ptr++;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level words are written LSB-first; reorder lanes for the MSB-first build.
  function automatic logic [31:0] rd(input logic [31:0] w);
    logic [31:0] r;
    if (!MSB) return w;
    for (int k = 0; k < PACK; k++) r[(PACK-1-k)*8 +: 8] = w[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [3:0] rk(input logic [3:0] k);
    logic [3:0] r;
    if (!MSB) return k;
    for (int i = 0; i < PACK; i++) r[PACK-1-i] = k[i];
    return r;
  endfunction

  task automatic tick;
    @(posedge rclk);
    #1;
  endtask

  task automatic drive(input bit rdy, input bit fl);
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  task automatic doReset;
    rrst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    wr_ptr = rd_ptr;
    exp_q.delete();
    @(posedge rclk);
    #1;
    rrst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.rst_before) begin
      doReset();
      for (int b = 1; b <= 8; b++) fifoPush(8'(b * 8'h11));
    end
    drive(v.ready, v.fl);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal($sformatf("vec%0d_rinc", idx), 32'(rinc), 32'(v.exp_rinc));
    checkVal($sformatf("vec%0d_valid", idx), 32'(out_valid), 32'(v.exp_valid));
    if (v.chk_data) begin
      checkVal($sformatf("vec%0d_data", idx), 32'(out_data), rd(v.exp_data));
      checkVal($sformatf("vec%0d_keep", idx), 32'(out_keep), 32'(rk(v.exp_keep)));
    end
    if (v.chk_cnt) checkVal($sformatf("vec%0d_cnt", idx), 32'(dut.cnt), 32'(v.exp_cnt));
  endtask

  // Reference model: words are consecutive groups of the bytes pushed, in push order.
  task automatic popWord(input int n, output logic [31:0] w, output logic [3:0] k);
    int lane;
    w = '0;
    k = '0;
    for (int j = 0; j < n; j++) begin
      lane = MSB ? (PACK - 1 - j) : j;
      w[lane*8 +: 8] = exp_q.pop_front();
      k[lane] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] ew, prev_data;
    logic [3:0]  ek, prev_keep;
    logic        prev_stall;
    int          pushed, leftover;

    //             rst rdy fl rinc vld chk data          keep  chkc cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 4'h0, 1'b1, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 3};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 3};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h88776655, 4'hF, 1'b1, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 3};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b1, 3};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b1, 3};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h88776655, 4'hF, 1'b1, 0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 0};

    // Reset state, with data waiting in the FIFO so rinc is truly held low.
    flush = 1'b0;
    out_ready = 1'b1;
    fifoPush(8'h5A);
    #2;
    checkVal("reset_rinc", 32'(rinc), 32'h0);
    checkVal("reset_valid", 32'(out_valid), 32'h0);
    checkVal("reset_data", 32'(out_data), 32'h0);
    checkVal("reset_keep", 32'(out_keep), 32'h0);
    checkVal("reset_cnt", 32'(dut.cnt), 32'h0);
    @(posedge rclk);
    #1;
    checkVal("reset_no_pop", 32'(rempty), 32'h0);

    // Streaming and backpressure vectors.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
      tick();
    end

    // Partial flush, then a flush with nothing accumulated.
    doReset();
    fifoPush(8'hA1);
    fifoPush(8'hB2);
    drive(1'b1, 1'b0); tick();
    tick();
    drive(1'b1, 1'b1);
    checkVal("pflush_rinc", 32'(rinc), 32'h0);
    checkVal("pflush_cnt", 32'(dut.cnt), 32'd2);
    tick();
    drive(1'b1, 1'b0);
    checkVal("pflush_valid", 32'(out_valid), 32'h1);
    checkVal("pflush_data", 32'(out_data), rd(32'h0000B2A1));
    checkVal("pflush_keep", 32'(out_keep), 32'(rk(4'h3)));
    tick();
    drive(1'b1, 1'b1);
    checkVal("pflush_cnt0", 32'(dut.cnt), 32'h0);
    checkVal("pflush_drain", 32'(out_valid), 32'h0);
    tick();
    drive(1'b1, 1'b0);
    checkVal("empty_flush_noword", 32'(out_valid), 32'h0);
    tick();

    // Flush coinciding with the word-completing pop.
    doReset();
    for (int b = 1; b <= 4; b++) fifoPush(8'(b));
    for (int s = 0; s < 3; s++) begin drive(1'b1, 1'b0); tick(); end
    drive(1'b1, 1'b1);
    checkVal("coinc_rinc", 32'(rinc), 32'h1);
    tick();
    drive(1'b1, 1'b0);
    checkVal("coinc_valid", 32'(out_valid), 32'h1);
    checkVal("coinc_data", 32'(out_data), rd(32'h04030201));
    checkVal("coinc_keep", 32'(out_keep), 32'hF);
    tick();
    checkVal("coinc_noextra1", 32'(out_valid), 32'h0);
    tick();
    checkVal("coinc_noextra2", 32'(out_valid), 32'h0);

    // Flush while the output register is blocked.
    doReset();
    fifoPush(8'h11); fifoPush(8'h22); fifoPush(8'h33); fifoPush(8'h44);
    fifoPush(8'hA5); fifoPush(8'hB6); fifoPush(8'hC7);
    for (int s = 0; s < 4; s++) begin drive(1'b1, 1'b0); tick(); end
    drive(1'b0, 1'b0);
    checkVal("blk_valid", 32'(out_valid), 32'h1);
    tick(); tick(); tick();
    drive(1'b0, 1'b1);
    checkVal("blk_cnt", 32'(dut.cnt), 32'd3);
    tick();
    fifoPush(8'hD8);
    drive(1'b0, 1'b1);
    checkVal("blk_state", 32'(dut.state), 32'(FLUSH_WAIT));
    checkVal("blk_rinc", 32'(rinc), 32'h0);
    checkVal("blk_hold", 32'(out_data), rd(32'h44332211));
    tick();
    drive(1'b1, 1'b0);
    checkVal("blk_rinc_wait", 32'(rinc), 32'h0);
    tick();
    drive(1'b1, 1'b0);
    checkVal("blk_pvalid", 32'(out_valid), 32'h1);
    checkVal("blk_pdata", 32'(out_data), rd(32'h00C7B6A5));
    checkVal("blk_pkeep", 32'(out_keep), 32'(rk(4'h7)));
    checkVal("blk_state_fill", 32'(dut.state), 32'(FILL));
    checkVal("blk_resume", 32'(rinc), 32'h1);
    tick();
    drive(1'b1, 1'b0);
    checkVal("blk_noextra", 32'(out_valid), 32'h0);
    checkVal("blk_cnt1", 32'(dut.cnt), 32'd1);
    tick();

    // Asynchronous reset mid-word with a pending output word.
    doReset();
    for (int b = 1; b <= 4; b++) fifoPush(8'(b));
    fifoPush(8'hE1); fifoPush(8'hE2);
    fifoPush(8'hC1); fifoPush(8'hC2); fifoPush(8'hC3); fifoPush(8'hC4);
    for (int s = 0; s < 6; s++) begin drive(1'b0, 1'b0); tick(); end
    checkVal("mrst_pre_valid", 32'(out_valid), 32'h1);
    rrst = 1'b1;
    #1;
    checkVal("mrst_valid", 32'(out_valid), 32'h0);
    checkVal("mrst_rinc", 32'(rinc), 32'h0);
    checkVal("mrst_cnt", 32'(dut.cnt), 32'h0);
    #1;
    rrst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 1'b0);
      checkVal($sformatf("mrst_pop%0d", s), 32'(rinc), 32'h1);
      tick();
    end
    drive(1'b1, 1'b0);
    checkVal("mrst_word_valid", 32'(out_valid), 32'h1);
    checkVal("mrst_word", 32'(out_data), rd(32'hC4C3C2C1));
    tick();

    // Random stream with random gaps and backpressure against the byte-order model.
    doReset();
    pushed = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_keep = '0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc < 800 && pushed < 203 && $urandom_range(0, 99) < 45) begin
        ew = $urandom;
        fifoPush(ew[7:0]);
        exp_q.push_back(ew[7:0]);
        pushed++;
      end
      drive((cyc >= 800) || ($urandom_range(0, 99) < 60), 1'b0);
      checkVal("rnd_rinc_empty", 32'(rinc && rempty), 32'h0);
      if (prev_stall) begin
        checkVal("rnd_hold_valid", 32'(out_valid), 32'h1);
        checkVal("rnd_hold_data", 32'(out_data), prev_data);
        checkVal("rnd_hold_keep", 32'(out_keep), 32'(prev_keep));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() < PACK) begin
          checkVal("rnd_unexpected_word", 32'(exp_q.size()), 32'(PACK));
        end else begin
          popWord(PACK, ew, ek);
          checkVal("rnd_data", 32'(out_data), ew);
          checkVal("rnd_keep", 32'(out_keep), 32'(ek));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_keep  = out_keep;
      tick();
    end
    leftover = pushed % PACK;
    checkVal("rnd_leftover", 32'(exp_q.size()), 32'(leftover));
    checkVal("rnd_fifo_drained", 32'(rempty), 32'h1);
    drive(1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b0);
    checkVal("rnd_tail_valid", 32'(out_valid), 32'(leftover != 0));
    if (leftover != 0) begin
      popWord(leftover, ew, ek);
      checkVal("rnd_tail_data", 32'(out_data), ew);
      checkVal("rnd_tail_keep", 32'(out_keep), 32'(ek));
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
